// File: rtl/hex_display_mux_if.sv
// Signal bundle between the observation datapath and the seven-segment scan driver.
// The master supplies the word and controls; the slave drives the pins and status.
interface hex_display_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic                    load;
   logic                    blank_lz;
   logic                    enable;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    pending;
   logic                    frame_start;

   modport master (
      output value, load, blank_lz, enable,
      input  seg, an, pending, frame_start
   );

   modport slave (
      input  value, load, blank_lz, enable,
      output seg, an, pending, frame_start
   );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode hex display driver.
// A shadow/display register pair keeps each shown frame consistent.
module hex_display_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hex_display_mux_if.slave       bus
);
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]        r_pre;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [4*NUM_DIGITS-1:0] r_display;
   logic                    r_pending;
   logic                    r_frame_start;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;

   logic                    w_adv;
   logic                    w_wrap;
   logic                    w_lead;
   logic [NUM_DIGITS-1:0]   w_lz;
   logic [3:0]              w_nib;
   logic                    w_blank;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS-1:0]   w_an;

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h2:    return 7'b0010010;
         4'h3:    return 7'b0000110;
         4'h4:    return 7'b1001100;
         4'h5:    return 7'b0100100;
         4'h6:    return 7'b0100000;
         4'h7:    return 7'b0001111;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0000100;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b1100000;
         4'hC:    return 7'b0110001;
         4'hD:    return 7'b1000010;
         4'hE:    return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   assign w_adv  = (r_pre == PRE_LAST);
   assign w_wrap = w_adv && (r_idx == IDX_LAST);

   // w_lz[i]: every display nibble from the top down to i is zero; digit 0 always shows.
   always_comb begin
      w_lz   = '0;
      w_lead = 1'b1;
      for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
         w_lead    = w_lead && (r_display[4*(i-1) +: 4] == 4'h0);
         w_lz[i-1] = w_lead;
      end
      w_lz[0] = 1'b0;
   end

   always_comb begin
      w_nib   = '0;
      w_blank = 1'b0;
      w_an    = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib   = r_display[4*i +: 4];
            w_blank = bus.blank_lz && w_lz[i];
            w_an[i] = ~bus.enable;
         end
      end
      w_seg = (!bus.enable || w_blank) ? 7'b1111111 : f_decode(w_nib);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pre         <= '0;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_display     <= '0;
         r_pending     <= 1'b0;
         r_frame_start <= 1'b0;
         r_seg         <= '1;
         r_an          <= '1;
      end else begin
         r_pre <= w_adv ? '0 : r_pre + PRE_W'(1);
         if (w_adv)
            r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
         if (w_wrap && r_pending)
            r_display <= r_shadow;
         // A load on the wrap edge still hands the old shadow over, then refills it.
         if (bus.load) begin
            r_shadow  <= bus.value;
            r_pending <= 1'b1;
         end else if (w_wrap) begin
            r_pending <= 1'b0;
         end
         r_frame_start <= w_wrap;
         r_seg         <= w_seg;
         r_an          <= w_an;
      end
   end

   assign bus.seg         = r_seg;
   assign bus.an          = r_an;
   assign bus.pending     = r_pending;
   assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux with NUM_DIGITS=4, SCAN_DIV=4 (16-cycle frame).
// Expected pin values come from the decode table and scan timing worked out by hand.
module tb_hex_display_mux;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   hex_display_mux_if #(.NUM_DIGITS(4)) ioif ();

   hex_display_mux #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ioif)
   );

   always #5 clk = ~clk;

   // Edges since reset release; phase = cyc % 16, digit shown after edge k is ((k-1)/4)%4.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic goto_phase(input int p);
      for (int i = 0; i < 40; i++) begin
         if (cyc % 16 == p) break;
         step();
      end
   endtask

   task automatic load_word(input logic [15:0] w);
      ioif.value = w;
      ioif.load  = 1'b1;
      step();
      ioif.load  = 1'b0;
   endtask

   function automatic logic [6:0] exp_seg(input logic [15:0] w, input int d, input logic blz);
      logic lz;
      lz = 1'b1;
      for (int j = 3; j >= d; j--) lz = lz && (w[4*j +: 4] == 4'h0);
      if (blz && lz && d != 0) return 7'b1111111;
      return SEG[w[4*d +: 4]];
   endfunction

   task automatic check_frame(input string tag, input logic [15:0] w, input logic blz);
      logic [3:0] ea;
      goto_phase(1);
      for (int d = 0; d < 4; d++) begin
         ea = ~(4'b0001 << d);
         chk($sformatf("%s an d%0d", tag, d), 32'(ioif.an), 32'(ea));
         chk($sformatf("%s seg d%0d", tag, d), 32'(ioif.seg), 32'(exp_seg(w, d, blz)));
         if (d < 3) repeat (4) step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
      logic [3:0]  ea;
      rst_n         = 1'b0;
      ioif.value    = '0;
      ioif.load     = 1'b0;
      ioif.blank_lz = 1'b0;
      ioif.enable   = 1'b1;

      // Reset and free-running scan
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst seg", 32'(ioif.seg), 32'h7F);
      chk("rst an", 32'(ioif.an), 32'hF);
      chk("rst fs", 32'(ioif.frame_start), 32'h0);
      chk("rst pend", 32'(ioif.pending), 32'h0);
      rst_n = 1'b1;
      step();
      chk("first an", 32'(ioif.an), 32'hE);
      chk("first seg", 32'(ioif.seg), 32'(7'b0000001));
      goto_phase(5);  chk("rot an1", 32'(ioif.an), 32'hD);
      goto_phase(9);  chk("rot an2", 32'(ioif.an), 32'hB);
      goto_phase(13); chk("rot an3", 32'(ioif.an), 32'h7);
      goto_phase(15); chk("fs pre", 32'(ioif.frame_start), 32'h0);
      step();         chk("fs wrap", 32'(ioif.frame_start), 32'h1);
      step();         chk("fs post", 32'(ioif.frame_start), 32'h0);
      chk("wrap an", 32'(ioif.an), 32'hE);

      // Decode sweep
      foreach (sweep[k]) begin
         goto_phase(2);
         load_word(sweep[k]);
         chk("sweep pend", 32'(ioif.pending), 32'h1);
         check_frame($sformatf("sweep%0d", k), sweep[k], 1'b0);
      end

      // Tear-free mid-frame update
      goto_phase(6);
      load_word(16'h1234);
      chk("tear pend", 32'(ioif.pending), 32'h1);
      goto_phase(9);  chk("tear old d2", 32'(ioif.seg), 32'(SEG[4'hE]));
      goto_phase(13); chk("tear old d3", 32'(ioif.seg), 32'(SEG[4'hF]));
      goto_phase(15); chk("tear pend pre", 32'(ioif.pending), 32'h1);
      step();
      chk("tear pend clr", 32'(ioif.pending), 32'h0);
      chk("tear fs", 32'(ioif.frame_start), 32'h1);
      check_frame("tear", 16'h1234, 1'b0);

      // Load coinciding with the wrap edge
      goto_phase(4);
      load_word(16'hAAAA);
      goto_phase(15);
      load_word(16'h5555);
      chk("coin pend", 32'(ioif.pending), 32'h1);
      chk("coin fs", 32'(ioif.frame_start), 32'h1);
      check_frame("coinA", 16'hAAAA, 1'b0);
      goto_phase(15); chk("coin pend2", 32'(ioif.pending), 32'h1);
      check_frame("coin5", 16'h5555, 1'b0);
      chk("coin pend3", 32'(ioif.pending), 32'h0);

      // Leading-zero blanking
      ioif.blank_lz = 1'b1;
      goto_phase(2);
      load_word(16'h0050);
      check_frame("blz50", 16'h0050, 1'b1);
      goto_phase(2);
      load_word(16'h0000);
      check_frame("blz0", 16'h0000, 1'b1);
      ioif.blank_lz = 1'b0;

      // Display enable
      goto_phase(6);
      ioif.enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("dis an %0d", i), 32'(ioif.an), 32'hF);
         chk($sformatf("dis seg %0d", i), 32'(ioif.seg), 32'h7F);
      end
      ioif.enable = 1'b1;
      step();
      ea = ~(4'b0001 << (((cyc - 1) / 4) % 4));
      chk("reen an", 32'(ioif.an), 32'(ea));
      chk("reen seg", 32'(ioif.seg), 32'(SEG[0]));

      // Reset mid-frame with a pending value
      goto_phase(4);
      load_word(16'h9999);
      chk("mrst pend pre", 32'(ioif.pending), 32'h1);
      rst_n = 1'b0;
      step();
      step();
      chk("mrst pend", 32'(ioif.pending), 32'h0);
      chk("mrst an", 32'(ioif.an), 32'hF);
      chk("mrst seg", 32'(ioif.seg), 32'h7F);
      rst_n = 1'b1;
      step();
      check_frame("mrst f0", 16'h0000, 1'b0);
      check_frame("mrst f1", 16'h0000, 1'b0);
      chk("mrst pend post", 32'(ioif.pending), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/hex_display_mux.md
# hex_display_mux

Time-multiplexed driver for a bank of common-anode seven-segment hex digits, parametrised in digit count and scan rate. It takes a packed hex word from the datapath (register file tap, PC, ALU result), double-buffers it so the displayed frame never tears, and scans one digit per scan slot. Leading-zero blanking and a global display enable are supported. It sits between the RISC-V debug/observation logic and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 4, number of hex digits driven (1..8)
- SCAN_DIV, 50000, clock cycles each digit stays lit (>=2)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- value  in  4*NUM_DIGITS  hex word; nibble i drives digit i, with digit 0 the least significant
- load  in  1  single-cycle strobe; captures value into the shadow register
- blank_lz  in  1  1 = blank leading zero digits
- enable  in  1  0 = all digits dark; scanning continues
- seg  out  7  {a,b,c,d,e,f,g}, active-low, registered
- an  out  NUM_DIGITS  digit select, one-hot active-low, registered
- pending  out  1  shadow value waiting for the next frame boundary
- frame_start  out  1  one-cycle pulse when the scan returns to digit 0

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. Digit index `idx` advances by one (modulo NUM_DIGITS) on the edge where `pre == SCAN_DIV-1`.
- Wrap edge: the edge where `idx` goes from NUM_DIGITS-1 to 0.
  - If `pending` is set, the display register takes the shadow register and `pending` clears.
  - `frame_start` is asserted for the following cycle.
- `load`:
  - Shadow register takes `value` and `pending` is set.
  - If `load` coincides with a wrap edge, the display register takes the old shadow (if it was pending). The new value goes into the shadow and `pending` stays 1.
  - Back-to-back loads overwrite the shadow; the last load before a wrap wins.
- Decode, with nibble shown as seg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111
- Leading-zero blanking: with blank_lz=1, digit i is blank when display nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never blanked, so an all-zero word shows a single "0".
- Blanked digit: `an` still selects it and `seg`=1111111.
- enable=0: `an` = all ones and `seg` = 1111111. `pre`, `idx`, shadow and pending logic keep running.

## Timing
- Reset, rst_n=0 sampled on a rising edge:
  - pre=0, idx=0
  - shadow=0, display=0, pending=0
  - seg=1111111, an=all ones, frame_start=0
- `seg` and `an` are registered from `idx`, the display register, blank_lz and enable. They reflect a change in those inputs one cycle later.
- First cycle after reset release: digit 0 is lit, showing "0", with an[0]=0.
- `load` to visible: the display register updates at the next wrap edge, and `seg` shows the new value one cycle after that.
  - Worst case: NUM_DIGITS*SCAN_DIV + 1 cycles.
- Each digit is lit for exactly SCAN_DIV cycles; one frame is NUM_DIGITS*SCAN_DIV cycles.
- blank_lz and enable are sampled every cycle and take effect one cycle later, with no frame alignment.
- Reset mid-scan discards the shadow, the display register and any pending value.
- NUM_DIGITS=1: every digit advance is a wrap edge; `an` is constant 0 while enabled.

## Test plan
- Bench parameters for all tests: NUM_DIGITS=4, SCAN_DIV=4.
1. Reset: hold rst_n=0 for 3 cycles, then release. Required: seg=1111111 and an=1111 during reset; next cycle an=1110, seg=0000001; an rotates 1110 -> 1101 -> 1011 -> 0111 every 4 cycles; frame_start pulses every 16 cycles.
2. Decode sweep: load 0x3210, then 0x7654, then 0xBA98, then 0xFEDC, each applied after a frame. Required: every digit matches the encoding list above, e.g. 0xF -> 0111000 on an=0111.
3. Tear-free update: load 0x1234 mid-frame. Required: pending=1; old value is kept on all digits until the wrap; pending=0 after the wrap; the next frame shows 4,3,2,1 on digits 0..3.
4. Coincident loads: load 0xAAAA, then load 0x5555 exactly on the wrap edge. Required: the frame after the wrap shows AAAA, pending=1, and the following frame shows 5555.
5. Blanking: load 0x0050 with blank_lz=1. Required: digits 3 and 2 give seg=1111111, digit 1 gives 0100100, digit 0 gives 0000001. Load 0x0000: only digit 0 lit, showing "0".
6. Enable and mid-frame reset: enable=0 for 10 cycles. Required: an=1111 throughout, and the scan position after re-enable is consistent with a free-running counter. Then pulse rst_n low mid-frame with pending=1. Required: pending=0 and display returns to "0000".
